// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/HI-LO sequencing controller.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_MTHI  = 3'd3,
    OP_MTLO  = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT,
    ST_FIX
  } state_e;

  localparam int DEFAULT_TIMEOUT = 127;
  localparam int DEFAULT_WDOG_W  = 7;

  // Correction that turns the high word of a signed 32x32 product into the
  // high word of the unsigned product of the same bit patterns.
  function automatic logic [31:0] unsigned_hi_adj(input logic [31:0] a,
                                                  input logic [31:0] b);
    return (a[31] ? b : 32'd0) + (b[31] ? a : 32'd0);
  endfunction

endpackage

// File: rtl/muldiv_fixup.sv
// Combinational signed-to-unsigned product correction; only the high word moves.
module muldiv_fixup
  import muldiv_pkg::*;
(
  input  logic [63:0] prod,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_unsigned,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  always_comb begin
    hi = prod[63:32];
    lo = prod[31:0];
    if (is_unsigned) begin
      hi = prod[63:32] + unsigned_hi_adj(a, b);
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer between execute stage and the shared Booth multiplier; owns HI/LO.
// Optional unsigned multiply support is built when MULDIV_UNSIGNED_EN is defined.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        err,
  output logic        mult_start,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic [63:0] mult_z,
  input  logic        mult_done
);

  localparam int WDOG_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                start_q, start_d;
  logic [31:0]         a_q, a_d;
  logic [31:0]         b_q, b_d;
  logic [63:0]         prod_q, prod_d;
  logic [31:0]         hi_q, hi_d;
  logic [31:0]         lo_q, lo_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic [31:0]         fix_hi, fix_lo;

`ifdef MULDIV_UNSIGNED_EN
  logic uns_q, uns_d;

  muldiv_fixup u_fixup (
    .prod        (prod_q),
    .a           (a_q),
    .b           (b_q),
    .is_unsigned (uns_q),
    .hi          (fix_hi),
    .lo          (fix_lo)
  );
`else
  assign fix_hi = prod_q[63:32];
  assign fix_lo = prod_q[31:0];
`endif

  always_comb begin
    // NOTE: every signal gets a hold default first so no path infers a latch.
    state_d = state_q;
    err_d   = 1'b0;
    start_d = start_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    wdog_d  = wdog_q;
`ifdef MULDIV_UNSIGNED_EN
    uns_d   = uns_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          case (op_e'(op))
            OP_MULT: begin
              a_d     = rs_val;
              b_d     = rt_val;
              start_d = 1'b1;
              wdog_d  = '0;
              state_d = ST_ARM;
`ifdef MULDIV_UNSIGNED_EN
              uns_d   = 1'b0;
`endif
            end
            OP_MULTU: begin
`ifdef MULDIV_UNSIGNED_EN
              a_d     = rs_val;
              b_d     = rt_val;
              start_d = 1'b1;
              wdog_d  = '0;
              state_d = ST_ARM;
              uns_d   = 1'b1;
`else
              err_d   = 1'b1;
`endif
            end
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            OP_NONE: ;
            default: err_d = 1'b1;
          endcase
        end
      end
      // mult_done may still be high from the previous product here.
      ST_ARM: state_d = ST_WAIT;
      ST_WAIT: begin
        if (mult_done) begin
          start_d = 1'b0;
          prod_d  = mult_z;
          state_d = ST_FIX;
        end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
          start_d = 1'b0;
          err_d   = 1'b1;
          wdog_d  = '0;
          state_d = ST_IDLE;
        end else begin
          wdog_d  = wdog_q + WDOG_W'(1);
        end
      end
      ST_FIX: begin
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      wdog_q  <= '0;
`ifdef MULDIV_UNSIGNED_EN
      uns_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      start_q <= start_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      wdog_q  <= wdog_d;
`ifdef MULDIV_UNSIGNED_EN
      uns_q   <= uns_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign err        = err_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign mult_start = start_q;
  assign mult_a     = a_q;
  assign mult_b     = b_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a behavioural multiplier of fixed latency.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, err, mult_start, mult_done;
  logic [31:0] hi, lo, mult_a, mult_b;
  logic [63:0] mult_z;

  int n_tests = 0;
  int n_fail  = 0;
  int cycles;

  muldiv_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .op         (op),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .busy       (busy),
    .hi         (hi),
    .lo         (lo),
    .err        (err),
    .mult_start (mult_start),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_z     (mult_z),
    .mult_done  (mult_done)
  );

  always #5 clk = ~clk;

  // Multiplier model: starts on a rising mult_start, raises done LAT edges later
  // and holds it until the next start. hang suppresses done.
  logic start_prev, run, hang;
  int   cnt;

  always @(posedge clk) begin
    if (reset) begin
      start_prev <= 1'b0;
      run        <= 1'b0;
      cnt        <= 0;
      mult_done  <= 1'b0;
      mult_z     <= '0;
    end else begin
      start_prev <= mult_start;
      if (mult_start && !start_prev) begin
        run       <= 1'b1;
        cnt       <= LAT;
        mult_done <= 1'b0;
      end else if (run && !hang) begin
        if (cnt == 1) begin
          run       <= 1'b0;
          mult_done <= 1'b1;
          mult_z    <= $signed({{32{mult_a[31]}}, mult_a}) * $signed({{32{mult_b[31]}}, mult_b});
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    req = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    req = 1'b0; op = 3'd0;
  endtask

  task automatic wait_idle(input int limit, output int n);
    n = 0;
    while (busy === 1'b1 && n < limit) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req = 1'b0; op = 3'd0; rs_val = '0; rt_val = '0; hang = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_hilo", {hi, lo}, 64'h0);
    check("rst_err", err, 1'b0);
    check("rst_start", mult_start, 1'b0);
    check("rst_ab", {mult_a, mult_b}, 64'h0);
    reset = 1'b0;
    @(negedge clk);

    // Reset while stuck in WAIT
    hang = 1'b1;
    issue(OP_MULT, 32'h11, 32'h22);
    check("acc_busy", busy, 1'b1);
    check("acc_start", mult_start, 1'b1);
    check("acc_ab", {mult_a, mult_b}, {32'h11, 32'h22});
    repeat (19) @(negedge clk);
    check("midwait_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; hang = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_start", mult_start, 1'b0);
    check("midrst_hilo", {hi, lo}, 64'h0);

    issue(OP_MULT, 32'd3, 32'd5);
    wait_idle(50, cycles);
    check("m3x5_idle", busy, 1'b0);
    check("m3x5_hilo", {hi, lo}, 64'h0000_0000_0000_000F);

    // Signed multiply with stall length
    issue(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_idle(50, cycles);
    check("sgn_stall", cycles, LAT + 3);
    check("sgn_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sgn_start", mult_start, 1'b0);

    // MULTU
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
`ifdef MULDIV_UNSIGNED_EN
    check("mu_err", err, 1'b0);
    wait_idle(50, cycles);
    check("mu_stall", cycles, LAT + 3);
    check("mu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
`else
    check("mu_err", err, 1'b1);
    check("mu_busy", busy, 1'b0);
    @(negedge clk);
    check("mu_err_clr", err, 1'b0);
    check("mu_start", mult_start, 1'b0);
    check("mu_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
`endif

    // Illegal op and MTLO
    issue(3'd6, 32'hDEAD_BEEF, 32'h0);
    check("ill_err", err, 1'b1);
    check("ill_busy", busy, 1'b0);
    issue(OP_MTLO, 32'hA5A5_A5A5, 32'h0);
    check("mtlo_err", err, 1'b0);
    check("mtlo_lo", lo, 32'hA5A5_A5A5);
    check("mtlo_busy", busy, 1'b0);

    // Back-to-back with stale done
    issue(OP_MULT, 32'd7, 32'd6);
    wait_idle(50, cycles);
    check("b2b1_hilo", {hi, lo}, 64'h0000_0000_0000_002A);
    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000);
    wait_idle(50, cycles);
    check("b2b2_stall", cycles, LAT + 3);
    check("b2b2_hilo", {hi, lo}, 64'h4000_0000_0000_0000);

    // Watchdog abort
    hang = 1'b1;
    issue(OP_MULT, 32'd1, 32'd1);
    wait_idle(300, cycles);
    check("wd_stall", cycles, 128);
    check("wd_err", err, 1'b1);
    check("wd_start", mult_start, 1'b0);
    check("wd_hilo", {hi, lo}, 64'h4000_0000_0000_0000);
    @(negedge clk);
    check("wd_err_clr", err, 1'b0);
    check("wd_busy", busy, 1'b0);
    hang = 1'b0;

    // MTHI held while busy
    issue(OP_MULT, 32'd2, 32'd3);
    req = 1'b1; op = OP_MTHI; rs_val = 32'h1234_5678;
    cycles = 0;
    while (busy === 1'b1 && cycles < 50) begin
      check("mthi_ign_hi", hi, 32'h4000_0000);
      cycles++;
      @(negedge clk);
    end
    check("mthi_fix_hilo", {hi, lo}, 64'h0000_0000_0000_0006);
    @(negedge clk);
    req = 1'b0; op = 3'd0;
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_lo", lo, 32'h0000_0006);
    check("mthi_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencing controller between the CPU execute stage and the shared multi-cycle Booth multiplier. It accepts multiply and HI/LO-move requests, drives the multiplier's level-held start handshake and stalls the pipeline while a product is pending. It owns the architectural HI/LO registers, applies the unsigned-product correction, and supervises the multiplier with a watchdog.

## Interface
- TIMEOUT, 127: maximum WAIT-state cycles before the operation is aborted.
- clk  in  1  system clock; all controller state updates on posedge.
- reset  in  1  synchronous, active-high.
- req  in  1  request valid from execute stage.
- op  in  3  muldiv_pkg op code: NONE=0, MULT=1, MULTU=2, MTHI=3, MTLO=4; 5-7 illegal.
- rs_val  in  32  operand a / move source.
- rt_val  in  32  operand b.
- busy  out  1  pipeline stall; high while a multiply is in flight.
- hi  out  32  HI register.
- lo  out  32  LO register.
- err  out  1  one-cycle pulse: illegal op, or watchdog abort.
- mult_start  out  1  level start to multiplier.
- mult_a  out  32  multiplier operand a, held stable while mult_start=1.
- mult_b  out  32  multiplier operand b, held stable while mult_start=1.
- mult_z  in  64  signed product.
- mult_done  in  1  multiplier done level; stays high until the multiplier's next start.

## Operation
- States: IDLE, ARM, WAIT, FIX.
- IDLE:
  - req & MULT/MULTU: latch rs_val/rt_val into mult_a/mult_b; latch signedness; assert mult_start -> ARM.
  - req & MTHI/MTLO: write rs_val to hi/lo next edge; stay IDLE.
  - req & op 5-7: err pulse; no state change.
  - NONE or req=0: no action.
- ARM: exactly one cycle; mult_done ignored (stale done from the previous product); -> WAIT.
- WAIT:
  - mult_done=1: drop mult_start, capture mult_z -> FIX.
  - Watchdog counter reaches TIMEOUT: drop mult_start, err pulse, hi/lo unchanged -> IDLE.
- FIX: write {hi,lo} = product (corrected per Configuration) -> IDLE.
- busy = (state != IDLE).
- Requests arriving while busy=1 are ignored; the requester holds req until it samples busy=0 with the op accepted.
- mult_start is never high in IDLE.
- Product arithmetic is 64-bit, modulo 2^64.

## Timing
- Reset values: busy=0, hi=0, lo=0, err=0, mult_start=0, mult_a=0, mult_b=0, state IDLE, watchdog 0.
- Reset mid-operation: returns to IDLE next edge and drops mult_start. The multiplier's own reset is driven by the same reset.
- Accept edge T:
  - busy=1 from T+1.
  - ARM occupies T+1.
  - WAIT runs from T+2 until mult_done is sampled at edge D.
  - FIX at D+1; hi/lo valid and busy=0 after edge D+2.
- Total stall = multiplier latency + 3 cycles.
- MTHI/MTLO: hi/lo updated at the accept edge; busy stays 0.
- A MULT accepted in the cycle after FIX is legal: back-to-back multiplies, no bubble beyond IDLE.
- Watchdog counts WAIT cycles only; it clears on entering ARM.

## Configuration
- MULDIV_UNSIGNED_EN defined:
  - MULTU supported.
  - In FIX: hi += (a[31] ? b : 0) + (b[31] ? a : 0), mod 2^32.
  - lo unchanged from the signed product.
- MULDIV_UNSIGNED_EN undefined:
  - MULTU treated as an illegal op: err pulse, not accepted.
  - FIX passes mult_z through unmodified.

## Structure
- muldiv_pkg: op code enum, state enum, default TIMEOUT constant, watchdog width (7 bits for default).
- Sub-module muldiv_fixup: combinational unsigned correction (mult_z, a, b, is_unsigned -> {hi,lo}). Instantiated only under MULDIV_UNSIGNED_EN.
- The multiplier is instantiated by the parent and connected through the mult_* ports.

## Test plan
- Reset mid-WAIT:
  - Stimulus: MULT, then reset asserted 20 cycles later.
  - Required: busy=0, mult_start=0, hi=lo=0 next edge.
  - Then MULT 3×5 -> hi=0, lo=0x0000000F.
- MULT signed:
  - Stimulus: rs=0xFFFFFFFF, rt=0x00000002.
  - Required: busy high for multiplier latency +3 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU, with MULDIV_UNSIGNED_EN:
  - Stimulus: rs=0xFFFFFFFF, rt=0x00000002.
  - Required: hi=0x00000001, lo=0xFFFFFFFE.
- MULTU, without MULDIV_UNSIGNED_EN:
  - Stimulus: any operands.
  - Required: err one cycle, busy stays 0, hi/lo unchanged.
- Back-to-back with stale done:
  - Stimulus: MULT 7×6, then MULT 0x80000000×0x80000000 accepted the cycle busy falls.
  - Required: second result not taken from stale done; hi=0x40000000, lo=0.
- Watchdog:
  - Stimulus: tie mult_done=0 after a MULT.
  - Required: err pulse after 127 WAIT cycles, mult_start=0, busy=0, hi/lo unchanged.
- MTHI during busy:
  - Stimulus: MTHI 0x12345678 while busy=1.
  - Required: ignored.
  - Follow-up: same request after busy falls -> hi=0x12345678 at the accept edge.
